jmp_seq_ctrl: RTL
=================

// Module: jmp_seq_ctrl
// PURPOSE
//  Sequencer for the 4-bit jump counter datapath. Runs a loadable counter from 0 to END_VAL
//  under start/stop control. A small programmable jump table redirects the count (from->to).
//  Reports busy/done/jumped status to the surrounding control logic.
// PARAMETERS
//  WIDTH    4   counter width (bits)
//  NJMP     2   number of jump-table entries
//  END_VAL  15  terminal count; RUN ends when count==END_VAL
// PORTS
//  clk       in   1         system clock, rising edge
//  resetN    in   1         asynchronous, active-low reset
//  start     in   1         level-sampled: IDLE->RUN or PAUSE->RUN
//  stop      in   1         level-sampled: RUN->PAUSE, PAUSE->IDLE
//  cfg_we    in   1         jump-table write strobe
//  cfg_addr  in   AW        entry index, AW=max(1,$clog2(NJMP))
//  cfg_valid in   1         entry enable
//  cfg_from  in   WIDTH     match value
//  cfg_to    in   WIDTH     jump target
//  count     out  WIDTH     current count (registered)
//  busy      out  1         state is RUN or PAUSE
//  done      out  1         1-cycle pulse, state DONE
//  jumped    out  1         high in the cycle count holds a jump target
// BEHAVIOUR
//  - Reset (async, resetN=0): state=IDLE, count=0, busy=0, done=0, jumped=0, all entries invalid.
//  - States IDLE, RUN, PAUSE, DONE; all outputs registered.
//  - IDLE: count holds. start=1 -> RUN, count<=0.
//  - RUN, per cycle:
//    - stop=1: ->PAUSE, count holds.
//    - else if count==END_VAL: ->DONE, count holds.
//    - else if a valid entry has from==count: count<=to of lowest-index match, jumped<=1.
//    - else count<=count+1, wrapping 2^WIDTH-1 -> 0 (END_VAL skipped by a jump => wrap).
//  - PAUSE: count holds. stop=1 -> IDLE, count<=0. Else start=1 -> RUN (resume from held count).
//  - DONE: done=1 for exactly one cycle, ->IDLE; count keeps END_VAL until next start.
//  - start & stop in the same cycle: stop wins in every state.
//  - Self-jump (to==from): count stalls at from; only stop exits; not an error.
//  - cfg_we applied only in IDLE/DONE; ignored while busy. cfg_addr>=NJMP ignored.
//  - Jump match uses the table contents at the clock edge; a write in that cycle takes effect next cycle.
// CONFIGURATION
//  JMP_SEQ_LOOP_EN defined:
//   - In RUN at count==END_VAL (no stop): count<=0, state stays RUN, done pulses 1 cycle (lap marker).
//   - Only stop leaves RUN.
//  JMP_SEQ_LOOP_EN undefined: RUN->DONE->IDLE as above.
// STRUCTURE
//  Package jmp_seq_pkg:
//   - state_t enum {IDLE,RUN,PAUSE,DONE}
//   - jmp_entry_t struct {valid, from, to}
//   - default WIDTH/END_VAL constants.
//  Sub-module jmp_seq_cnt: loadable WIDTH counter (en, load, load_val, async resetN).
//  jmp_seq_ctrl holds the FSM, jump table, and match/priority logic.
// TESTING (WIDTH=4, NJMP=2, END_VAL=15)
//  1. Empty table, start 1 cycle -> count 0..15 on successive cycles; done=1 one cycle after 15; busy 0.
//  2. entry0={1,3,10}, start -> count 0,1,2,3,10,11..15; jumped=1 only while count==10.
//  3. entry0={1,5,9}, entry1={1,5,12} -> after 5 count=9 (lowest index wins).
//  4. stop at count 6 -> PAUSE, holds 6; start -> 7 next; stop,stop -> IDLE, count 0;
//     start&stop together in IDLE -> stays IDLE.
//  5. cfg_we while busy -> table unchanged (seq from test 2 repeats); resetN=0 at count 7 ->
//     count 0, busy 0 immediately, table cleared.
//  6. JMP_SEQ_LOOP_EN: count 15 -> 0, busy stays 1, done pulses each lap; stop -> PAUSE.

Source files
------------

// File: rtl/jmp_seq_pkg.sv
// rtl/jmp_seq_pkg.sv - shared types and defaults for the jump sequencer
// Purpose: FSM state encoding, jump-table entry layout and default sizing
//          used by jmp_seq_ctrl and its bench.
// Ports:   none (package)
package jmp_seq_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_NJMP    = 2;
  localparam int DEF_END_VAL = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Entries are sized by DEF_WIDTH; the controller's WIDTH must match it.
  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] from;
    logic [DEF_WIDTH-1:0] to;
  } jmp_entry_t;

endpackage

// File: rtl/jmp_seq_cnt.sv
// rtl/jmp_seq_cnt.sv - loadable up-counter for the jump sequencer
// Purpose: WIDTH-bit counter; load has priority over increment, and the
//          increment wraps naturally from all-ones to zero.
// Ports:   clk, resetN (async active-low), en (increment), load,
//          load_val [WIDTH-1:0], count [WIDTH-1:0] (registered)
module jmp_seq_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= r_count + WIDTH'(1'b1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/jmp_seq_ctrl.sv
// rtl/jmp_seq_ctrl.sv - start/stop sequencer with a programmable jump table
// Purpose: runs the counter from 0 to END_VAL; table entries redirect the
//          count (from->to, lowest index wins). Optional macro
//          JMP_SEQ_LOOP_EN makes RUN wrap to 0 at END_VAL with a done
//          lap pulse instead of going through DONE.
// Ports:   clk, resetN (async active-low), start, stop,
//          cfg_we/cfg_addr/cfg_valid/cfg_from/cfg_to (table write),
//          count [WIDTH-1:0], busy, done, jumped (all registered)
module jmp_seq_ctrl
  import jmp_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NJMP    = DEF_NJMP,
  parameter int END_VAL = DEF_END_VAL,
  parameter int AW      = (NJMP > 1) ? $clog2(NJMP) : 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_from,
  input  logic [WIDTH-1:0] cfg_to,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             jumped
);

  localparam logic [WIDTH-1:0] L_END = WIDTH'(END_VAL);

  state_t           r_state;
  state_t           w_state_nxt;
  jmp_entry_t       r_tbl [NJMP];
  logic             r_busy;
  logic             r_done;
  logic             r_jumped;
  logic [WIDTH-1:0] w_count;
  logic             w_cnt_en;
  logic             w_cnt_load;
  logic [WIDTH-1:0] w_load_val;
  logic             w_done_nxt;
  logic             w_jumped_nxt;
  logic             w_hit;
  logic [WIDTH-1:0] w_hit_to;
  logic             w_cfg_ok;

  jmp_seq_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .resetN   (resetN),
    .en       (w_cnt_en),
    .load     (w_cnt_load),
    .load_val (w_load_val),
    .count    (w_count)
  );

  // Scan from the top index down so the lowest matching index is the last
  // assignment and therefore wins.
  always_comb begin
    w_hit    = 1'b0;
    w_hit_to = '0;
    for (int i = NJMP - 1; i >= 0; i--) begin
      if (r_tbl[i].valid && (r_tbl[i].from == w_count)) begin
        w_hit    = 1'b1;
        w_hit_to = r_tbl[i].to;
      end
    end
  end

  // Table is only writable while the sequencer is not busy.
  assign w_cfg_ok = cfg_we && ((r_state == IDLE) || (r_state == DONE))
                    && (int'(cfg_addr) < NJMP);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NJMP; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (w_cfg_ok) begin
      r_tbl[cfg_addr] <= '{valid: cfg_valid, from: cfg_from, to: cfg_to};
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_en     = 1'b0;
    w_cnt_load   = 1'b0;
    w_load_val   = '0;
    w_done_nxt   = 1'b0;
    w_jumped_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_state_nxt = RUN;
          w_cnt_load  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = PAUSE;
        end else if (w_count == L_END) begin
          w_done_nxt = 1'b1;
`ifdef JMP_SEQ_LOOP_EN
          w_cnt_load = 1'b1;
`else
          w_state_nxt = DONE;
`endif
        end else if (w_hit) begin
          w_cnt_load   = 1'b1;
          w_load_val   = w_hit_to;
          w_jumped_nxt = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_cnt_load  = 1'b1;
        end else if (start) begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_jumped <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
      r_done   <= w_done_nxt;
      r_jumped <= w_jumped_nxt;
    end
  end

  assign count  = w_count;
  assign busy   = r_busy;
  assign done   = r_done;
  assign jumped = r_jumped;

endmodule
